// File: rtl/ahb_timer_satellite_if.sv
// AHB-Lite bus bundle between the AHB multiplexor (master side) and the timer satellite.
// Signal names follow the AHB-Lite convention used by the rest of the bus fabric.
interface ahb_timer_satellite_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_timer_satellite.sv
// AHB-Lite satellite exposing a RISC-V style machine timer (mtime/mtimecmp) with a
// prescaler, configurable data-phase wait states, two-cycle ERROR responses and timer_irq.
module ahb_timer_satellite #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                        clk,
    input  logic                        nrst,
    ahb_timer_satellite_if.slave        bus,
    output logic                        timer_irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [2:0] LP_WAIT_LAST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    localparam logic [2:0] IDX_MTIME_LO = 3'd0;
    localparam logic [2:0] IDX_MTIME_HI = 3'd1;
    localparam logic [2:0] IDX_CMP_LO   = 3'd2;
    localparam logic [2:0] IDX_CMP_HI   = 3'd3;
    localparam logic [2:0] IDX_CTRL     = 3'd4;
    localparam logic [2:0] IDX_PRESCALE = 3'd5;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic        w_latch;
    logic [2:0]  r_idx;
    logic        r_write;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [1:0]  r_ctrl;
    logic [15:0] r_prescale;
    logic [15:0] r_pre_cnt;
    logic [31:0] r_hi_shadow;
    logic        r_irq;

    logic        w_accept;
    logic        w_addr_err;
    logic        w_commit_wr;
    logic        w_commit_rd;
    logic        w_tick;
    logic [31:0] w_rd_mux;
    logic        w_unused_bits;

    assign w_accept   = bus.hsel & bus.htrans[1] & bus.hready;
    assign w_addr_err = (bus.hsize != 3'b010) | (bus.haddr[1:0] != 2'b00)
                      | (bus.haddr[4:0] >= 5'h18);
    assign w_unused_bits = ^{bus.haddr[31:5], bus.htrans[0]};

    // NOTE: next-state logic assigns every output a default first so no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_latch        = 1'b0;
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (w_accept) begin
                    w_latch        = 1'b1;
                    w_wait_cnt_nxt = 3'd0;
                    if (w_addr_err)            w_state_nxt = S_ERR1;
                    else if (WAIT_STATES == 0) w_state_nxt = S_DATA;
                    else                       w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == LP_WAIT_LAST) w_state_nxt = S_DATA;
                else                            w_wait_cnt_nxt = r_wait_cnt + 3'd1;
            end
            S_ERR1:  w_state_nxt = S_ERR2;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 3'd0;
            r_idx      <= 3'd0;
            r_write    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_latch) begin
                r_idx   <= bus.haddr[4:2];
                r_write <= bus.hwrite;
            end
        end
    end

    assign w_commit_wr = (r_state == S_DATA) &  r_write;
    assign w_commit_rd = (r_state == S_DATA) & ~r_write;
    assign w_tick      = r_ctrl[0] & (r_pre_cnt == r_prescale);

    always_comb begin
        w_rd_mux = 32'h0;
        case (r_idx)
            IDX_MTIME_LO: w_rd_mux = r_mtime[31:0];
            IDX_MTIME_HI: w_rd_mux = r_hi_shadow;
            IDX_CMP_LO:   w_rd_mux = r_mtimecmp[31:0];
            IDX_CMP_HI:   w_rd_mux = r_mtimecmp[63:32];
            IDX_CTRL:     w_rd_mux = {30'h0, r_ctrl};
            IDX_PRESCALE: w_rd_mux = {16'h0, r_prescale};
            default:      w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mtime     <= 64'h0;
            r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_ctrl      <= 2'b00;
            r_prescale  <= 16'h0;
            r_pre_cnt   <= 16'h0;
            r_hi_shadow <= 32'h0;
            r_irq       <= 1'b0;
        end else begin
            // A bus write to either mtime half takes priority and swallows a coincident tick.
            if (w_commit_wr && r_idx == IDX_MTIME_LO)      r_mtime <= {r_mtime[63:32], bus.hwdata};
            else if (w_commit_wr && r_idx == IDX_MTIME_HI) r_mtime <= {bus.hwdata, r_mtime[31:0]};
            else if (w_tick)                               r_mtime <= r_mtime + 64'd1;

            if (w_commit_wr && r_idx == IDX_PRESCALE) r_pre_cnt <= 16'h0;
            else if (r_ctrl[0])                       r_pre_cnt <= w_tick ? 16'h0 : r_pre_cnt + 16'd1;

            if (w_commit_wr && r_idx == IDX_CMP_LO)   r_mtimecmp[31:0]  <= bus.hwdata;
            if (w_commit_wr && r_idx == IDX_CMP_HI)   r_mtimecmp[63:32] <= bus.hwdata;
            if (w_commit_wr && r_idx == IDX_CTRL)     r_ctrl            <= bus.hwdata[1:0];
            if (w_commit_wr && r_idx == IDX_PRESCALE) r_prescale        <= bus.hwdata[15:0];
            if (w_commit_rd && r_idx == IDX_MTIME_LO) r_hi_shadow       <= r_mtime[63:32];

            r_irq <= r_ctrl[1] & (r_mtime >= r_mtimecmp);
        end
    end

    assign bus.hreadyout = (r_state != S_WAIT) && (r_state != S_ERR1);
    assign bus.hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign bus.hrdata    = w_commit_rd ? w_rd_mux : 32'h0;
    assign timer_irq     = r_irq;

endmodule
